// File: rtl/datapath_ctrl_pkg.sv
// datapath_ctrl_pkg
//   Shared definitions for the datapath control sequencer: FSM state
//   encodings, the ALU NOP opcode and the packed-instruction field layout.
//   Instruction layout, MSB first: {sel_mux, sel_alu[2:0], rd, rs1, rs2},
//   where each register field is numreg bits wide.
package datapath_ctrl_pkg;

   localparam int NUMREG_DEF = 5;
   localparam int CNTW_DEF   = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      EXEC = 2'd2,
      WB   = 2'd3
   } state_t;

   // This opcode retires straight from EXEC without a write-back cycle
   localparam logic [2:0] ALU_NOP = 3'b111;

   // Field offsets as functions of the register-address width
   localparam int RS2_LSB = 0;

   function automatic int rs1_lsb(input int n);
      return n;
   endfunction

   function automatic int rd_lsb(input int n);
      return 2 * n;
   endfunction

   function automatic int alu_lsb(input int n);
      return 3 * n;
   endfunction

   function automatic int mux_bit(input int n);
      return 3 * n + 3;
   endfunction

   function automatic int instr_w(input int n);
      return 3 * n + 4;
   endfunction

endpackage

// File: rtl/datapath_ctrl_if.sv
// datapath_ctrl_if
//   Bundle between the instruction source / datapath and the controller.
//   slave  : controller side (takes instructions + stall, drives selects)
//   master : source/datapath side
//   Signals: instr_valid, instr, instr_ready, stall, sel_mux, sel_alu,
//            selread1, selread2, selwr, wr_en, busy, done, instr_count.
interface datapath_ctrl_if
   import datapath_ctrl_pkg::*;
#(
   parameter int numreg = NUMREG_DEF,
   parameter int CNTW   = CNTW_DEF
) ();

   logic                         instr_valid;
   logic [instr_w(numreg)-1:0]   instr;
   logic                         instr_ready;
   logic                         stall;
   logic                         sel_mux;
   logic [2:0]                   sel_alu;
   logic [numreg-1:0]            selread1;
   logic [numreg-1:0]            selread2;
   logic [numreg-1:0]            selwr;
   logic                         wr_en;
   logic                         busy;
   logic                         done;
   logic [CNTW-1:0]              instr_count;

   modport slave (
      input  instr_valid, instr, stall,
      output instr_ready, sel_mux, sel_alu, selread1, selread2, selwr,
             wr_en, busy, done, instr_count
   );

   modport master (
      output instr_valid, instr, stall,
      input  instr_ready, sel_mux, sel_alu, selread1, selread2, selwr,
             wr_en, busy, done, instr_count
   );

endinterface

// File: rtl/datapath_ctrl_decode.sv
// datapath_ctrl_decode
//   Purely combinational split of a packed instruction into its fields.
//   Ports: instr (in, packed instruction); sel_mux, sel_alu, rd, rs1, rs2 (out).
module datapath_ctrl_decode
   import datapath_ctrl_pkg::*;
#(
   parameter int numreg = NUMREG_DEF
) (
   input  logic [instr_w(numreg)-1:0] instr,
   output logic                       sel_mux,
   output logic [2:0]                 sel_alu,
   output logic [numreg-1:0]          rd,
   output logic [numreg-1:0]          rs1,
   output logic [numreg-1:0]          rs2
);

   localparam int RS1_LSB = rs1_lsb(numreg);
   localparam int RD_LSB  = rd_lsb(numreg);
   localparam int ALU_LSB = alu_lsb(numreg);
   localparam int MUX_BIT = mux_bit(numreg);

   assign rs2     = instr[RS2_LSB +: numreg];
   assign rs1     = instr[RS1_LSB +: numreg];
   assign rd      = instr[RD_LSB  +: numreg];
   assign sel_alu = instr[ALU_LSB +: 3];
   assign sel_mux = instr[MUX_BIT];

endmodule

// File: rtl/datapath_ctrl.sv
// datapath_ctrl
//   Sequencer for the register-file/ALU datapath. Takes one instruction at a
//   time over a valid/ready handshake and steps it through READ -> EXEC -> WB,
//   pulsing wr_en in WB and done on retirement. NOP opcodes retire from EXEC.
//   Ports: clk, rst (sync, active high); bus (datapath_ctrl_if.slave) carrying
//          the instruction handshake, stall, datapath selects, wr_en, busy,
//          done and the retired-instruction counter.
module datapath_ctrl
   import datapath_ctrl_pkg::*;
#(
   parameter int numreg = NUMREG_DEF,
   parameter int CNTW   = CNTW_DEF
) (
   input  logic            clk,
   input  logic            rst,
   datapath_ctrl_if.slave  bus
);

   logic              dec_mux;
   logic [2:0]        dec_alu;
   logic [numreg-1:0] dec_rd, dec_rs1, dec_rs2;

   datapath_ctrl_decode #(.numreg(numreg)) u_decode (
      .instr   (bus.instr),
      .sel_mux (dec_mux),
      .sel_alu (dec_alu),
      .rd      (dec_rd),
      .rs1     (dec_rs1),
      .rs2     (dec_rs2)
   );

   state_t            state_q, state_d;
   logic              sel_mux_q, sel_mux_d;
   logic [2:0]        sel_alu_q, sel_alu_d;
   logic [numreg-1:0] rd_q, rd_d;
   logic [numreg-1:0] rs1_q, rs1_d;
   logic [numreg-1:0] rs2_q, rs2_d;
   logic [CNTW-1:0]   cnt_q, cnt_d;
   logic              ready, wr_en, done;

   // The select registers double as the instruction latch: they load only on
   // accept, so they stay stable from READ through WB and hold in IDLE.
   always_comb begin
      state_d   = state_q;
      sel_mux_d = sel_mux_q;
      sel_alu_d = sel_alu_q;
      rd_d      = rd_q;
      rs1_d     = rs1_q;
      rs2_d     = rs2_q;
      cnt_d     = cnt_q;
      wr_en     = 1'b0;
      done      = 1'b0;
      // Gated by rst so nothing is offered during a reset cycle
      ready     = (state_q == IDLE) && !rst;
      case (state_q)
         IDLE: begin
            if (bus.instr_valid && ready) begin
               state_d   = READ;
               sel_mux_d = dec_mux;
               sel_alu_d = dec_alu;
               rd_d      = dec_rd;
               rs1_d     = dec_rs1;
               rs2_d     = dec_rs2;
            end
         end
         READ: state_d = EXEC;
         EXEC: begin
            if (!bus.stall) begin
               if (sel_alu_q == ALU_NOP) begin
                  done    = !rst;
                  state_d = IDLE;
               end else begin
                  state_d = WB;
               end
            end
         end
         WB: begin
            // A reset landing here aborts the write and the retirement
            wr_en   = !rst;
            done    = !rst;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (done) cnt_d = cnt_q + CNTW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         sel_mux_q <= 1'b0;
         sel_alu_q <= 3'b000;
         rd_q      <= '0;
         rs1_q     <= '0;
         rs2_q     <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         sel_mux_q <= sel_mux_d;
         sel_alu_q <= sel_alu_d;
         rd_q      <= rd_d;
         rs1_q     <= rs1_d;
         rs2_q     <= rs2_d;
         cnt_q     <= cnt_d;
      end
   end

   assign bus.instr_ready = ready;
   assign bus.sel_mux     = sel_mux_q;
   assign bus.sel_alu     = sel_alu_q;
   assign bus.selread1    = rs1_q;
   assign bus.selread2    = rs2_q;
   assign bus.selwr       = rd_q;
   assign bus.wr_en       = wr_en;
   assign bus.done        = done;
   assign bus.busy        = (state_q != IDLE);
   assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_datapath_ctrl.sv
// tb_datapath_ctrl
//   Directed bench for datapath_ctrl: reset, single op, stall, NOP,
//   back-to-back issue, mid-instruction abort, and counter wrap (on a second
//   instance with a 3-bit counter so the wrap is reachable quickly).
module tb_datapath_ctrl;
   import datapath_ctrl_pkg::*;

   localparam int NR  = 5;
   localparam int CW  = 16;
   localparam int CW2 = 3;

   logic clk  = 1'b0;
   logic rst  = 1'b1;
   logic rst2 = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   datapath_ctrl_if #(.numreg(NR), .CNTW(CW))  bus  ();
   datapath_ctrl_if #(.numreg(NR), .CNTW(CW2)) bus2 ();

   datapath_ctrl #(.numreg(NR), .CNTW(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   datapath_ctrl #(.numreg(NR), .CNTW(CW2)) dut_wrap (
      .clk (clk),
      .rst (rst2),
      .bus (bus2)
   );

   function automatic logic [18:0] mk(input logic m, input logic [2:0] a,
                                      input logic [4:0] rd, input logic [4:0] r1,
                                      input logic [4:0] r2);
      return {m, a, rd, r1, r2};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Present one instruction for a single accept edge; returns in READ
   task automatic send(input logic [18:0] ins);
      bus.instr_valid = 1'b1;
      bus.instr       = ins;
      tick();
      bus.instr_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running, completion expected");
      $fatal(1, "timeout");
   end

   logic [18:0] prog [3];
   logic [4:0]  exp_wr [3];
   int          cyc;

   initial begin
      bus.instr_valid  = 1'b1;
      bus.instr        = mk(1'b0, 3'b001, 5'd3, 5'd4, 5'd5);
      bus.stall        = 1'b0;
      bus2.instr_valid = 1'b0;
      bus2.instr       = '0;
      bus2.stall       = 1'b0;

      // ---- reset: two cycles with valid high, nothing accepted
      tick();
      chk("rst_ready",  32'(bus.instr_ready), 0);
      chk("rst_busy",   32'(bus.busy), 0);
      chk("rst_wr_en",  32'(bus.wr_en), 0);
      chk("rst_done",   32'(bus.done), 0);
      chk("rst_count",  32'(bus.instr_count), 0);
      chk("rst_selwr",  32'(bus.selwr), 0);
      chk("rst_selrd1", 32'(bus.selread1), 0);
      chk("rst_alu",    32'(bus.sel_alu), 0);
      chk("rst_mux",    32'(bus.sel_mux), 0);
      tick();
      chk("rst2_busy",  32'(bus.busy), 0);
      rst = 1'b0;
      bus.instr_valid = 1'b0;
      #1;
      chk("post_rst_ready", 32'(bus.instr_ready), 1);

      // ---- single op: rd=2, rs1=0, rs2=1
      send(mk(1'b0, 3'b000, 5'd2, 5'd0, 5'd1));
      chk("op_rd_selrd1", 32'(bus.selread1), 0);
      chk("op_rd_selrd2", 32'(bus.selread2), 1);
      chk("op_rd_selwr",  32'(bus.selwr), 2);
      chk("op_rd_busy",   32'(bus.busy), 1);
      chk("op_rd_ready",  32'(bus.instr_ready), 0);
      chk("op_rd_wr_en",  32'(bus.wr_en), 0);
      tick();
      chk("op_ex_wr_en",  32'(bus.wr_en), 0);
      chk("op_ex_done",   32'(bus.done), 0);
      tick();
      chk("op_wb_wr_en",  32'(bus.wr_en), 1);
      chk("op_wb_done",   32'(bus.done), 1);
      chk("op_wb_selwr",  32'(bus.selwr), 2);
      tick();
      chk("op_idle_wr_en", 32'(bus.wr_en), 0);
      chk("op_idle_done",  32'(bus.done), 0);
      chk("op_idle_busy",  32'(bus.busy), 0);
      chk("op_count",      32'(bus.instr_count), 1);
      chk("op_hold_selrd2", 32'(bus.selread2), 1);

      // ---- stall: three stalled EXEC cycles push WB to T+6
      send(mk(1'b1, 3'b010, 5'd7, 5'd3, 5'd4));
      bus.stall = 1'b1;                 // ignored in READ
      tick();                           // T+2 EXEC
      chk("st_t2_wr_en", 32'(bus.wr_en), 0);
      chk("st_t2_selwr", 32'(bus.selwr), 7);
      tick();                           // T+3
      tick();                           // T+4
      chk("st_t4_wr_en", 32'(bus.wr_en), 0);
      chk("st_t4_busy",  32'(bus.busy), 1);
      tick();                           // T+5, still EXEC
      chk("st_t5_wr_en", 32'(bus.wr_en), 0);
      chk("st_t5_selrd1", 32'(bus.selread1), 3);
      bus.stall = 1'b0;
      #1;
      chk("st_t5_done", 32'(bus.done), 0);
      tick();                           // T+6 WB
      chk("st_wb_wr_en", 32'(bus.wr_en), 1);
      chk("st_wb_done",  32'(bus.done), 1);
      chk("st_wb_alu",   32'(bus.sel_alu), 2);
      chk("st_wb_mux",   32'(bus.sel_mux), 1);
      chk("st_wb_selrd2", 32'(bus.selread2), 4);
      bus.stall = 1'b1;                 // ignored in WB
      #1;
      chk("st_wb_stall_ign", 32'(bus.wr_en), 1);
      tick();
      chk("st_idle_busy",  32'(bus.busy), 0);
      chk("st_idle_wr_en", 32'(bus.wr_en), 0);
      chk("st_count",      32'(bus.instr_count), 2);
      bus.stall = 1'b0;

      // ---- NOP retires from EXEC without a write
      send(mk(1'b0, 3'b111, 5'd9, 5'd10, 5'd11));
      chk("nop_rd_done", 32'(bus.done), 0);
      tick();
      chk("nop_ex_done",  32'(bus.done), 1);
      chk("nop_ex_wr_en", 32'(bus.wr_en), 0);
      chk("nop_ex_alu",   32'(bus.sel_alu), 7);
      tick();
      chk("nop_idle_busy", 32'(bus.busy), 0);
      chk("nop_idle_done", 32'(bus.done), 0);
      chk("nop_idle_wr_en", 32'(bus.wr_en), 0);
      chk("nop_count",     32'(bus.instr_count), 3);

      // ---- back-to-back with valid held high
      prog[0] = mk(1'b0, 3'b001, 5'd1,  5'd2,  5'd3);
      prog[1] = mk(1'b1, 3'b011, 5'd4,  5'd5,  5'd6);
      prog[2] = mk(1'b0, 3'b100, 5'd31, 5'd30, 5'd29);
      exp_wr[0] = 5'd1; exp_wr[1] = 5'd4; exp_wr[2] = 5'd31;
      bus.instr_valid = 1'b1;
      bus.instr       = prog[0];
      for (int i = 0; i < 3; i++) begin
         tick();                        // READ
         chk("b2b_rd_selwr", 32'(bus.selwr), 32'(exp_wr[i]));
         chk("b2b_rd_ready", 32'(bus.instr_ready), 0);
         if (i < 2) bus.instr = prog[i+1];
         else       bus.instr_valid = 1'b0;
         tick();                        // EXEC
         chk("b2b_ex_ready", 32'(bus.instr_ready), 0);
         chk("b2b_ex_selwr", 32'(bus.selwr), 32'(exp_wr[i]));
         tick();                        // WB
         chk("b2b_wb_wr_en", 32'(bus.wr_en), 1);
         chk("b2b_wb_ready", 32'(bus.instr_ready), 0);
         tick();                        // IDLE
         chk("b2b_idle_ready", 32'(bus.instr_ready), 1);
         chk("b2b_idle_busy",  32'(bus.busy), 0);
      end
      chk("b2b_count", 32'(bus.instr_count), 6);

      // ---- reset during EXEC aborts the instruction
      send(mk(1'b0, 3'b000, 5'd5, 5'd1, 5'd2));
      tick();                           // EXEC
      rst = 1'b1;
      #1;
      chk("ab_ex_wr_en", 32'(bus.wr_en), 0);
      chk("ab_ex_done",  32'(bus.done), 0);
      tick();
      chk("ab_busy",  32'(bus.busy), 0);
      chk("ab_selwr", 32'(bus.selwr), 0);
      chk("ab_count", 32'(bus.instr_count), 0);
      rst = 1'b0;
      tick();
      chk("ab_after_busy",  32'(bus.busy), 0);
      chk("ab_after_wr_en", 32'(bus.wr_en), 0);
      chk("ab_after_ready", 32'(bus.instr_ready), 1);

      // ---- counter wrap on the 3-bit instance, NOPs streamed back-to-back
      bus2.instr       = mk(1'b0, 3'b111, 5'd1, 5'd1, 5'd1);
      bus2.instr_valid = 1'b1;
      tick();
      rst2 = 1'b0;
      for (int n = 1; n <= 8; n++) begin
         cyc = 0;
         while (bus2.done !== 1'b1 && cyc < 8) begin
            tick();
            cyc++;
         end
         chk("wrap_done_seen", 32'(bus2.done), 1);
         tick();
         chk("wrap_count", 32'(bus2.instr_count), 32'(n % 8));
      end
      bus2.instr_valid = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
